// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit CPU control unit: FSM states, opcodes, ALU codes and
// the bundle of control lines driven into the datapath.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH1,
        FETCH2,
        EXEC_ALU,
        LOAD,
        STORE,
        JUMP,
        HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef struct packed {
        logic       pc_select;
        logic       pc_enable;
        logic       adr_select;
        logic       ir1_en;
        logic       ir2_en;
        logic       reg_select;
        logic       wd3_select;
        logic       reg_write;
        logic       op1_sel;
        logic       op2_sel;
        logic       alu_out_en;
        logic [2:0] alu_control;
        logic       mem_write;
        logic       halted;
    } ctrl_t;

    // Control lines for a given state; alu only matters in EXEC_ALU.
    function automatic ctrl_t state_outputs(input state_t s, input logic [2:0] alu);
        ctrl_t c;
        c = '0;
        c.alu_control = ALU_ADD;
        case (s)
            FETCH1: begin
                c.ir1_en    = 1'b1;
                c.pc_enable = 1'b1;
                c.op2_sel   = 1'b1;
            end
            FETCH2: begin
                c.ir2_en    = 1'b1;
                c.pc_enable = 1'b1;
                c.op2_sel   = 1'b1;
            end
            EXEC_ALU: begin
                c.reg_select  = 1'b1;
                c.op1_sel     = 1'b1;
                c.alu_control = alu;
                c.wd3_select  = 1'b1;
                c.reg_write   = 1'b1;
                c.alu_out_en  = 1'b1;
            end
            LOAD: begin
                c.adr_select = 1'b1;
                c.reg_write  = 1'b1;
            end
            STORE: begin
                c.adr_select = 1'b1;
                c.mem_write  = 1'b1;
            end
            JUMP: begin
                c.pc_select = 1'b1;
                c.pc_enable = 1'b1;
            end
            HALT:    c.halted = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/op_decoder.sv
// Combinational opcode decode: picks the execute state entered from FETCH2 and
// the ALU operation used there.
module op_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output state_t     exec_state,
    output logic [2:0] alu_control
);

    always_comb begin
        exec_state  = FETCH1;
        alu_control = ALU_ADD;
        case (opcode)
            OP_ADD: exec_state = EXEC_ALU;
            OP_SUB: begin
                exec_state  = EXEC_ALU;
                alu_control = ALU_SUB;
            end
            OP_AND: begin
                exec_state  = EXEC_ALU;
                alu_control = ALU_AND;
            end
            OP_OR: begin
                exec_state  = EXEC_ALU;
                alu_control = ALU_OR;
            end
            OP_LD:   exec_state = LOAD;
            OP_ST:   exec_state = STORE;
            OP_JMP:  exec_state = JUMP;
            OP_HALT: exec_state = HALT;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle Moore control unit: two fetch cycles, then one execute cycle chosen
// from the opcode held in IR1.
module control_fsm
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    output logic       pcSelect,
    output logic       pcEnable,
    output logic       adrSelect,
    output logic       ir1En,
    output logic       ir2En,
    output logic       regSelect,
    output logic       wd3Select,
    output logic       regWrite,
    output logic       op1Sel,
    output logic       op2Sel,
    output logic       aluOutEn,
    output logic [2:0] aluControl,
    output logic       memWrite,
    output logic       halted
);

    state_t     state;
    state_t     next_state;
    state_t     exec_state;
    logic [2:0] dec_alu;
    ctrl_t      ctrl;

    op_decoder u_op_decoder (
        .opcode      (opcode),
        .exec_state  (exec_state),
        .alu_control (dec_alu)
    );

    always_comb begin
        next_state = state;
        case (state)
            FETCH1:                      next_state = FETCH2;
            FETCH2:                      next_state = exec_state;
            EXEC_ALU, LOAD, STORE, JUMP: next_state = FETCH1;
            HALT:                        next_state = HALT;
            default:                     next_state = FETCH1;
        endcase
    end

    // Control lines are registered together with the state so they describe the
    // state being entered; IR1 stays put through execute, so the ALU code is stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH1;
            ctrl  <= state_outputs(FETCH1, ALU_ADD);
        end else begin
            state <= next_state;
            ctrl  <= state_outputs(next_state, dec_alu);
        end
    end

    // Strobes are gated by reset directly so nothing is written in a reset cycle.
    assign pcSelect   = ctrl.pc_select;
    assign pcEnable   = ctrl.pc_enable  & ~reset;
    assign adrSelect  = ctrl.adr_select;
    assign ir1En      = ctrl.ir1_en     & ~reset;
    assign ir2En      = ctrl.ir2_en     & ~reset;
    assign regSelect  = ctrl.reg_select;
    assign wd3Select  = ctrl.wd3_select;
    assign regWrite   = ctrl.reg_write  & ~reset;
    assign op1Sel     = ctrl.op1_sel;
    assign op2Sel     = ctrl.op2_sel;
    assign aluOutEn   = ctrl.alu_out_en & ~reset;
    assign aluControl = ctrl.alu_control;
    assign memWrite   = ctrl.mem_write  & ~reset;
    assign halted     = ctrl.halted     & ~reset;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: an instruction-level model queues the expected
// control word of every cycle, a negedge monitor pops and compares.
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       pcSelect, pcEnable, adrSelect, ir1En, ir2En, regSelect, wd3Select;
    logic       regWrite, op1Sel, op2Sel, aluOutEn, memWrite, halted;
    logic [2:0] aluControl;

    control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .pcSelect   (pcSelect),
        .pcEnable   (pcEnable),
        .adrSelect  (adrSelect),
        .ir1En      (ir1En),
        .ir2En      (ir2En),
        .regSelect  (regSelect),
        .wd3Select  (wd3Select),
        .regWrite   (regWrite),
        .op1Sel     (op1Sel),
        .op2Sel     (op2Sel),
        .aluOutEn   (aluOutEn),
        .aluControl (aluControl),
        .memWrite   (memWrite),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Word layout: pcSelect pcEnable adrSelect ir1En ir2En regSelect wd3Select regWrite
    //              op1Sel op2Sel aluOutEn aluControl[2:0] memWrite halted
    localparam logic [15:0] STROBES = 16'h5923;
    localparam logic [15:0] ALL     = 16'hFFFF;

    typedef enum int {PH_F1, PH_F2, PH_ALU, PH_LD, PH_ST, PH_JMP} phase_t;

    typedef struct {
        logic [15:0] word;
        logic [15:0] mask;
        string       name;
    } exp_t;

    exp_t       exp_q[$];
    phase_t     pending[$];
    logic [3:0] prog[$];
    logic [3:0] cur_op;
    bit         halted_m;
    bit         halt_next;
    bit         running;
    int         compared;
    int         mismatched;

    function automatic logic [15:0] mk(input bit pc_sel, input bit pc_en, input bit adr,
                                       input bit i1, input bit i2, input bit rsel,
                                       input bit wd3, input bit rw, input bit o1,
                                       input bit o2, input bit aen, input logic [2:0] alu,
                                       input bit mw, input bit h);
        return {pc_sel, pc_en, adr, i1, i2, rsel, wd3, rw, o1, o2, aen, alu, mw, h};
    endfunction

    // Expected control word for each phase of an instruction.
    function automatic logic [15:0] phase_word(input phase_t ph, input logic [3:0] op);
        logic [2:0] alu;
        alu = 3'(op - 4'd1);
        case (ph)
            PH_F1:   return mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 3'd0, 0, 0);
            PH_F2:   return mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 3'd0, 0, 0);
            PH_ALU:  return mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1, alu,  0, 0);
            PH_LD:   return mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 3'd0, 0, 0);
            PH_ST:   return mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0);
            default: return mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0);
        endcase
    endfunction

    function automatic string phase_name(input phase_t ph);
        case (ph)
            PH_F1:   return "fetch1";
            PH_F2:   return "fetch2";
            PH_ALU:  return "exec_alu";
            PH_LD:   return "load";
            PH_ST:   return "store";
            default: return "jump";
        endcase
    endfunction

    // One clock cycle: drive inputs just after the edge and queue what the DUT must show.
    task automatic step(input bit rst);
        exp_t   e;
        phase_t ph;
        @(posedge clk);
        #1;
        running = 1'b1;
        reset   = rst;
        if (rst) begin
            opcode = 4'($urandom);
            e = '{16'h0000, STROBES, "reset"};
            exp_q.push_back(e);
            pending.delete();
            halted_m  = 1'b0;
            halt_next = 1'b0;
            return;
        end
        if (!halted_m && pending.size() == 0 && halt_next) halted_m = 1'b1;
        if (halted_m) begin
            opcode = 4'($urandom);
            e = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1), ALL, "halt"};
            exp_q.push_back(e);
            return;
        end
        if (pending.size() == 0) begin
            cur_op = (prog.size() > 0) ? prog.pop_front() : 4'($urandom_range(0, 15));
            pending.push_back(PH_F1);
            pending.push_back(PH_F2);
            if (cur_op >= 4'h1 && cur_op <= 4'h4) pending.push_back(PH_ALU);
            else if (cur_op == 4'h6)            pending.push_back(PH_LD);
            else if (cur_op == 4'h7)            pending.push_back(PH_ST);
            else if (cur_op == 4'h8)            pending.push_back(PH_JMP);
            else if (cur_op == 4'hF)            halt_next = 1'b1;
        end
        ph = pending.pop_front();
        // IR1 only holds the new opcode once the FETCH1 edge has loaded it.
        opcode = (ph == PH_F1) ? 4'($urandom) : cur_op;
        e = '{phase_word(ph, cur_op), ALL, phase_name(ph)};
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] act;
        if (running) begin
            act = {pcSelect, pcEnable, adrSelect, ir1En, ir2En, regSelect, wd3Select,
                   regWrite, op1Sel, op2Sel, aluOutEn, aluControl, memWrite, halted};
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL scoreboard_empty: got %h, required an expected entry", act);
            end else begin
                e = exp_q.pop_front();
                if ((act & e.mask) !== (e.word & e.mask)) begin
                    mismatched++;
                    $display("FAIL %s @%0t: got %h, required %h (mask %h)",
                             e.name, $time, act & e.mask, e.word & e.mask, e.mask);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        running    = 1'b0;
        halted_m   = 1'b0;
        halt_next  = 1'b0;
        cur_op     = 4'h0;
        reset      = 1'b1;
        opcode     = 4'h0;

        for (int i = 0; i < 3; i++) step(1'b1);

        // Directed program: SUB, ST, LD, JMP, undefined, HALT.
        prog.push_back(4'h2);
        prog.push_back(4'h7);
        prog.push_back(4'h6);
        prog.push_back(4'h8);
        prog.push_back(4'h5);
        prog.push_back(4'hF);
        for (int i = 0; i < 40 && !halted_m; i++) step(1'b0);
        for (int i = 0; i < 12; i++) step(1'b0);
        step(1'b1);

        // Reset landing in EXEC_ALU must suppress the register write.
        prog.push_back(4'h1);
        for (int i = 0; i < 10 && !(pending.size() > 0 && pending[0] == PH_ALU); i++)
            step(1'b0);
        step(1'b1);
        for (int i = 0; i < 6; i++) step(1'b0);

        for (int i = 0; i < 600; i++) step($urandom_range(0, 19) == 0);

        step(1'b1);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
